// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Brief    : Parametrised inter-stage pipeline register. Valid/ready
//            handshake with a 2-entry skid buffer, so up_ready_o is
//            registered. Supports flush, hold (bubble insertion), occupancy
//            reporting and a saturating stall-cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
    parameter int unsigned DATA_W      = 160,
    parameter int unsigned ZERO_BUBBLE = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold_i,
    input  logic              up_valid_i,
    input  logic [DATA_W-1:0] up_data_i,
    output logic              up_ready_o,
    output logic              down_valid_o,
    input  logic              down_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // State encoding equals the number of entries held, so the state
    // register doubles as the registered occupancy output.
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main_q;
    logic [DATA_W-1:0] r_skid_q;
    logic              r_up_ready;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_main_v;
    logic              w_acc;
    logic              w_emit;
    logic              w_down_valid;
    logic              w_main_ld_up;
    logic              w_main_ld_skid;
    logic              w_skid_ld;

    assign w_main_v     = (r_state != S_EMPTY);
    assign w_down_valid = w_main_v & ~hold_i;
    assign w_acc        = up_valid_i & r_up_ready;
    assign w_emit       = w_down_valid & down_ready_i;

    // State register plus the registered ready that mirrors "next != FULL".
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state    <= S_EMPTY;
            r_up_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_up_ready <= (w_state_nxt != S_FULL);
        end
    end

    // Next-state and data-movement decode for the skid buffer.
    always_comb begin
        w_state_nxt    = r_state;
        w_main_ld_up   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_acc) begin
                    w_main_ld_up = 1'b1;
                    w_state_nxt  = S_ONE;
                end
            end
            S_ONE: begin
                if (w_acc && w_emit) begin
                    w_main_ld_up = 1'b1;
                end else if (w_acc) begin
                    w_skid_ld   = 1'b1;
                    w_state_nxt = S_FULL;
                end else if (w_emit) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                // No accept here: up_ready_o is low whenever we are FULL.
                if (w_emit) begin
                    w_main_ld_skid = 1'b1;
                    w_state_nxt    = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    // Payload storage; flush scrubs both entries to zero.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_main_q <= '0;
            r_skid_q <= '0;
        end else begin
            if (w_main_ld_up) begin
                r_main_q <= up_data_i;
            end else if (w_main_ld_skid) begin
                r_main_q <= r_skid_q;
            end
            if (w_skid_ld) begin
                r_skid_q <= up_data_i;
            end
        end
    end

    // Saturating count of cycles a valid entry sat behind hold_i; survives flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_v && hold_i && !flush && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Output decode; bubbles show as all-zero payload when ZERO_BUBBLE is set.
    always_comb begin
        up_ready_o   = r_up_ready;
        down_valid_o = w_down_valid;
        occupancy_o  = r_state;
        stall_cnt_o  = r_stall_cnt;
        data_o       = r_main_q;
        if ((ZERO_BUBBLE != 0) && !w_down_valid) begin
            data_o = '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_buf
// Brief    : Self-checking bench for pipe_stage_buf (DATA_W=8, CNT_W=4,
//            ZERO_BUBBLE=1). Table of per-cycle vectors plus a payload
//            scoreboard for ordering / loss / duplication.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              hold_i;
    logic              up_valid_i;
    logic [DATA_W-1:0] up_data_i;
    logic              up_ready_o;
    logic              down_valid_o;
    logic              down_ready_i;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        occupancy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    pipe_stage_buf #(
        .DATA_W      (DATA_W),
        .ZERO_BUBBLE (1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .hold_i       (hold_i),
        .up_valid_i   (up_valid_i),
        .up_data_i    (up_data_i),
        .up_ready_o   (up_ready_o),
        .down_valid_o (down_valid_o),
        .down_ready_i (down_ready_i),
        .data_o       (data_o),
        .occupancy_o  (occupancy_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       flush;
        logic       hold;
        logic       uv;
        logic [7:0] ud;
        logic       dr;
        logic       e_ur;
        logic       e_dv;
        logic [7:0] e_d;
        logic [1:0] e_occ;
        logic [3:0] e_st;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         n_vec = 0;
    int         n_bad = 0;

    task automatic add(input logic r, input logic f, input logic h, input logic uv,
                       input logic [7:0] ud, input logic dr, input logic e_ur,
                       input logic e_dv, input logic [7:0] e_d, input logic [1:0] e_occ,
                       input logic [3:0] e_st);
        vec_t v;
        v.rst = r; v.flush = f; v.hold = h; v.uv = uv; v.ud = ud; v.dr = dr;
        v.e_ur = e_ur; v.e_dv = e_dv; v.e_d = e_d; v.e_occ = e_occ; v.e_st = e_st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // ---------------- stimulus table ----------------
        //   rst flush hold uv  ud     dr | ur dv d      occ st
        // streaming
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 1, 8'h11, 1, 1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 1, 8'h22, 1, 1, 1, 8'h11, 1, 0);
        add(0, 0, 0, 1, 8'h33, 1, 1, 1, 8'h22, 1, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h33, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // backpressure into the skid entry
        add(0, 0, 0, 1, 8'hA1, 0, 1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 1, 8'hA2, 0, 1, 1, 8'hA1, 1, 0);
        add(0, 0, 0, 1, 8'hA3, 0, 0, 1, 8'hA1, 2, 0);
        add(0, 0, 0, 1, 8'hA3, 1, 0, 1, 8'hA1, 2, 0);
        add(0, 0, 0, 1, 8'hA3, 1, 1, 1, 8'hA2, 1, 0);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hA3, 1, 0);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // hold bubble
        add(0, 0, 0, 1, 8'h5C, 0, 1, 0, 8'h00, 0, 0);
        add(0, 0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 0);
        add(0, 0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 1);
        add(0, 0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1, 2);
        add(0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h5C, 1, 3);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'h5C, 1, 3);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 3);
        // flush while FULL with a concurrent offer of 0x77
        add(0, 0, 0, 1, 8'hB1, 0, 1, 0, 8'h00, 0, 3);
        add(0, 0, 0, 1, 8'hB2, 0, 1, 1, 8'hB1, 1, 3);
        add(0, 1, 0, 1, 8'h77, 0, 0, 1, 8'hB1, 2, 3);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 3);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 3);
        // accept continues under hold until FULL
        add(0, 0, 1, 1, 8'hC1, 1, 1, 0, 8'h00, 0, 3);
        add(0, 0, 1, 1, 8'hC2, 1, 1, 0, 8'h00, 1, 3);
        add(0, 0, 1, 1, 8'hC3, 1, 0, 0, 8'h00, 2, 4);
        add(0, 0, 0, 0, 8'h00, 1, 0, 1, 8'hC1, 2, 5);
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hC2, 1, 5);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 5);
        // reset mid-operation while FULL with stall count 7
        add(0, 0, 0, 1, 8'hD1, 0, 1, 0, 8'h00, 0, 5);
        add(0, 0, 1, 1, 8'hD2, 0, 1, 0, 8'h00, 1, 5);
        add(0, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00, 2, 6);
        add(1, 0, 0, 0, 8'h00, 0, 0, 1, 8'hD1, 2, 7);
        add(0, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0);
        // counter saturation: 20 held cycles
        add(0, 0, 0, 1, 8'hE1, 0, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 20; i++) begin
            add(0, 0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 1, (i > 15) ? 4'd15 : 4'(i));
        end
        add(0, 0, 0, 0, 8'h00, 1, 1, 1, 8'hE1, 1, 15);
        add(0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 15);

        // ---------------- reset ----------------
        rst = 1'b1; flush = 1'b0; hold_i = 1'b0; up_valid_i = 1'b0;
        up_data_i = '0; down_ready_i = 1'b0;
        repeat (2) @(posedge clk);

        // ---------------- apply ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            rst          = vecs[i].rst;
            flush        = vecs[i].flush;
            hold_i       = vecs[i].hold;
            up_valid_i   = vecs[i].uv;
            up_data_i    = vecs[i].ud;
            down_ready_i = vecs[i].dr;
            @(negedge clk);
            chk("up_ready",   i, 32'(up_ready_o),   32'(vecs[i].e_ur));
            chk("down_valid", i, 32'(down_valid_o), 32'(vecs[i].e_dv));
            chk("data",       i, 32'(data_o),       32'(vecs[i].e_d));
            chk("occupancy",  i, 32'(occupancy_o),  32'(vecs[i].e_occ));
            chk("stall_cnt",  i, 32'(stall_cnt_o),  32'(vecs[i].e_st));
            // scoreboard: retire first, then record the newly accepted payload
            if (down_valid_o && down_ready_i) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", i, 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    chk("sb_order", i, 32'(data_o), 32'(sb.pop_front()));
                end
            end
            if (up_valid_i && up_ready_o) begin
                sb.push_back(up_data_i);
            end
            if (rst || flush) begin
                sb.delete();
            end
            @(posedge clk);
        end
        #1;
        up_valid_i = 1'b0; down_ready_i = 1'b0; hold_i = 1'b0;
        chk("sb_leftover", 0, 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
